socket_rr: RTL and testbench
============================

Name: socket_rr

Overview:
- Multi-channel successor of the single-FIFO socket.
- N_CH independent input FIFOs feed one downstream output through a round-robin arbiter. The arbiter honours the downstream full backpressure.
- Adds per-channel fill level, almost-full flags and a channel tag on every output word.
- Sits between several producer blocks and one consumer stage in the streaming pipeline.

Parameters:
- DATA_WIDTH, 8, width of one data word.
- DEPTH, 4, words per channel FIFO; must be a power of 2 and >= 2.
- N_CH, 2, number of input channels; >= 1.
- AFULL_THRESH, 3, o_afull[c] asserts when the channel c level is >= this value; 1..DEPTH.
- Derived: CH_W = max(1, $clog2(N_CH)).
- Derived: LVL_W = $clog2(DEPTH)+1.

Ports:
- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  N_CH*DATA_WIDTH  packed input words; channel c is at [c*DATA_WIDTH +: DATA_WIDTH].
- i_wr_en  in  N_CH  per-channel write strobe.
- o_full  out  N_CH  per-channel FIFO full (level == DEPTH).
- o_afull  out  N_CH  per-channel almost full (level >= AFULL_THRESH).
- o_level  out  N_CH*LVL_W  per-channel registered word count.
- i_full  in  1  downstream full; while high, no word is popped.
- o_data  out  DATA_WIDTH  output word.
- o_ch  out  CH_W  index of the channel that produced o_data.
- o_dv  out  1  o_data and o_ch are valid this cycle.

Behaviour:
- Reset (async assert, release on any edge): for every channel, wr_ptr = 0, rd_ptr = 0, level = 0.
  - o_full = 0, o_afull = 0, o_level = 0, o_data = 0, o_ch = 0, o_dv = 0.
  - last_grant = N_CH-1, so channel 0 has first priority.
  - Reset mid-operation discards all stored words; an in-flight o_dv drops immediately.
- Write, channel c: accepted when i_wr_en[c] = 1 and o_full[c] = 0 (registered value).
  - The word is stored at wr_ptr, wr_ptr increments modulo DEPTH, level += 1.
  - A write while full is dropped silently; pointers and level are unchanged.
  - A write is rejected while full even if the same channel is popped that cycle.
- Arbitration, each cycle: req[c] = (level[c] != 0).
  - Pop only if i_full = 0 and any req is set.
  - Grant the first requesting channel scanning last_grant+1, last_grant+2, ... modulo N_CH.
  - On a pop: last_grant = granted channel, rd_ptr increments modulo DEPTH, level -= 1.
  - When no pop occurs, last_grant holds.
  - Exactly one pop per cycle maximum.
- Output register: on a pop, o_data = mem[c][rd_ptr], o_ch = c, o_dv = 1, all at the next edge (1-cycle pop-to-valid latency).
  - Without a pop, o_dv = 0 at the next edge; o_data and o_ch hold their previous values.
- i_full is sampled in the pop cycle only. A word already in the output register is presented regardless of i_full.
  - The consumer must raise i_full with one word of slack.
- Same channel written and popped in one cycle: both occur, level unchanged.
- A write into an empty channel is poppable the next cycle; minimum i_wr_en to o_dv = 2 cycles.
- Pointers wrap with natural LVL_W-1 bit overflow. Level never exceeds DEPTH and never underflows.
- o_full, o_afull and o_level are registered and update on the same edge as level.
- N_CH = 1 degenerates to a single FIFO plus controller; o_ch = 0 always.

Optional Feature:
- Macro: SOCKET_RR_OVF_EN.
- Defined: adds input i_ovf_clr (1 bit) and output o_ovf (N_CH bits).
  - o_ovf[c] is a sticky flag, set on the edge after a write to channel c while full.
  - Cleared by i_rst or i_ovf_clr = 1; set has priority over clear in the same cycle.
  - Reset value is 0.
- Undefined: both ports are absent; overflow writes are dropped with no indication.

Test Plan:
- Reset, then write 0xA1 to ch0 at cycle 0, i_full = 0 -> o_dv = 1 at cycle 2 with o_data = 0xA1, o_ch = 0; o_level ch0 goes 1 then 0.
- N_CH = 2: fill ch0 with 0x10..0x13 and ch1 with 0x20..0x23, then release i_full -> output order 0x10, 0x20, 0x11, 0x21, 0x12, 0x22, 0x13, 0x23, with o_dv high for 8 consecutive cycles.
- Fill ch0 with 4 words, then write 0xFF while full -> o_full[0] = 1, word dropped, level stays 4; with SOCKET_RR_OVF_EN, o_ovf[0] = 1 until i_ovf_clr is pulsed.
- Hold i_full = 1 with both channels non-empty for 5 cycles -> no pops, o_dv = 0, levels constant; drop i_full -> pops resume from the channel after last_grant.
- Write and pop ch1 every cycle at level 2 -> level stays 2, o_afull[1] = 0 with AFULL_THRESH = 3; one extra write -> o_afull[1] = 1.
- Assert i_rst while o_dv = 1 and levels are non-zero -> o_dv, o_level and o_full are 0 immediately; the first word written after release is the first word output.

Source files
------------

// File: rtl/socket_rr.sv
// Multi-channel socket: N_CH input FIFOs merged onto one output via a round-robin arbiter.
// Optional sticky overflow flags are enabled by defining SOCKET_RR_OVF_EN.
module socket_rr #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int N_CH         = 2,
    parameter int AFULL_THRESH = 3,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_CH*DATA_WIDTH-1:0] i_data,
    input  logic [N_CH-1:0]            i_wr_en,
    output logic [N_CH-1:0]            o_full,
    output logic [N_CH-1:0]            o_afull,
    output logic [N_CH*LVL_W-1:0]      o_level,
    input  logic                       i_full,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [CH_W-1:0]            o_ch,
    output logic                       o_dv
`ifdef SOCKET_RR_OVF_EN
    ,
    input  logic                       i_ovf_clr,
    output logic [N_CH-1:0]            o_ovf
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [N_CH][DEPTH];
    logic [PTR_W-1:0]      wr_ptr [N_CH];
    logic [PTR_W-1:0]      rd_ptr [N_CH];
    logic [LVL_W-1:0]      level [N_CH];
    logic [LVL_W-1:0]      level_nxt [N_CH];
    logic [N_CH-1:0]       req;
    logic [N_CH-1:0]       wr_ok;
    logic [N_CH-1:0]       pop_c;
    logic [CH_W-1:0]       last_grant;
    logic [CH_W-1:0]       gnt;
    logic                  gnt_valid;
    logic                  pop;

    // Full is the registered flag, so a write is refused even when the same channel pops.
    always_comb begin
        req     = '0;
        wr_ok   = '0;
        o_level = '0;
        for (int c = 0; c < N_CH; c++) begin
            req[c]                     = (level[c] != '0);
            wr_ok[c]                   = i_wr_en[c] && !o_full[c];
            o_level[c*LVL_W +: LVL_W]  = level[c];
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!gnt_valid && req[(int'(last_grant) + k) % N_CH]) begin
                gnt_valid = 1'b1;
                gnt       = CH_W'((int'(last_grant) + k) % N_CH);
            end
        end
    end

    assign pop = gnt_valid && !i_full;

    always_comb begin
        pop_c = '0;
        for (int c = 0; c < N_CH; c++) begin
            pop_c[c]     = pop && (gnt == CH_W'(c));
            level_nxt[c] = level[c] + LVL_W'(wr_ok[c]) - LVL_W'(pop_c[c]);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (wr_ok[c]) begin
                mem[c][wr_ptr[c]] <= i_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                level[c]  <= '0;
            end
            o_full     <= '0;
            o_afull    <= '0;
            last_grant <= CH_W'(N_CH - 1);
            o_dv       <= 1'b0;
            o_data     <= '0;
            o_ch       <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_ok[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                end
                if (pop_c[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                end
                level[c]   <= level_nxt[c];
                o_full[c]  <= (level_nxt[c] == LVL_W'(DEPTH));
                o_afull[c] <= (level_nxt[c] >= LVL_W'(AFULL_THRESH));
            end
            o_dv <= pop;
            if (pop) begin
                o_data     <= mem[gnt][rd_ptr[gnt]];
                o_ch       <= gnt;
                last_grant <= gnt;
            end
        end
    end

`ifdef SOCKET_RR_OVF_EN
    // Set wins over clear so an overflow coinciding with a clear is never lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ovf <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (i_wr_en[c] && o_full[c]) begin
                    o_ovf[c] <= 1'b1;
                end else if (i_ovf_clr) begin
                    o_ovf[c] <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_socket_rr.sv
// Scoreboard bench for socket_rr (N_CH=2, DEPTH=4, AFULL_THRESH=3); directed vectors.
// Overflow checks are included when SOCKET_RR_OVF_EN is defined.
module tb_socket_rr;
    localparam int DW    = 8;
    localparam int CH_W  = 1;
    localparam int LVL_W = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2*DW-1:0]   i_data = '0;
    logic [1:0]        i_wr_en = '0;
    logic [1:0]        o_full;
    logic [1:0]        o_afull;
    logic [2*LVL_W-1:0] o_level;
    logic              i_full = 1'b0;
    logic [DW-1:0]     o_data;
    logic [CH_W-1:0]   o_ch;
    logic              o_dv;
`ifdef SOCKET_RR_OVF_EN
    logic              i_ovf_clr = 1'b0;
    logic [1:0]        o_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    logic [CH_W+DW-1:0] exp_q [$];

    socket_rr #(.DATA_WIDTH(8), .DEPTH(4), .N_CH(2), .AFULL_THRESH(3)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (i_data),
        .i_wr_en (i_wr_en),
        .o_full  (o_full),
        .o_afull (o_afull),
        .o_level (o_level),
        .i_full  (i_full),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_dv    (o_dv)
`ifdef SOCKET_RR_OVF_EN
        ,
        .i_ovf_clr (i_ovf_clr),
        .o_ovf     (o_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_wr_en = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int lvl(input int c);
        return int'(o_level[c*LVL_W +: LVL_W]);
    endfunction

    // Output monitor: every valid word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && o_dv) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got ch=%0d data=0x%0h expected nothing", o_ch, o_data);
            end else begin
                logic [CH_W+DW-1:0] e;
                e = exp_q.pop_front();
                if ({o_ch, o_data} != e) begin
                    failures++;
                    $display("FAIL out_word: got ch=%0d data=0x%0h expected ch=%0d data=0x%0h",
                             o_ch, o_data, e[DW +: CH_W], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_dv", int'(o_dv), 0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_full", int'(o_full), 0);
        chk("rst_afull", int'(o_afull), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_ch", int'(o_ch), 0);
        rst = 1'b0;

        // Single word latency
        i_data  = {8'h00, 8'hA1};
        i_wr_en = 2'b01;
        exp_q.push_back({1'b0, 8'hA1});
        tick();
        i_wr_en = '0;
        chk("t1_level_after_wr", lvl(0), 1);
        chk("t1_dv_cycle1", int'(o_dv), 0);
        tick();
        chk("t1_level_after_pop", lvl(0), 0);
        chk("t1_dv_cycle2", int'(o_dv), 1);
        chk("t1_data", int'(o_data), 'hA1);
        tick();

        // Interleaved round robin over two full channels
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data  = {8'(8'h20 + i), 8'(8'h10 + i)};
            i_wr_en = 2'b11;
            tick();
        end
        i_wr_en = '0;
        chk("t2_level0", lvl(0), 4);
        chk("t2_level1", lvl(1), 4);
        chk("t2_full", int'(o_full), 3);
        chk("t2_afull", int'(o_afull), 3);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 8'(8'h10 + i)});
            exp_q.push_back({1'b1, 8'(8'h20 + i)});
        end
        i_full = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("t2_dv_streak", int'(o_dv), 1);
            tick();
        end
        chk("t2_dv_end", int'(o_dv), 0);
        chk("t2_level_end", int'(o_level), 0);

        // Overflow write is dropped
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_data  = {8'h00, 8'(8'h30 + i)};
            i_wr_en = 2'b01;
            tick();
        end
        chk("t3_full", int'(o_full[0]), 1);
        chk("t3_level_full", lvl(0), 4);
        i_data = {8'h00, 8'hFF};
        tick();
        i_wr_en = '0;
        chk("t3_level_ovf", lvl(0), 4);
        chk("t3_full_ovf", int'(o_full[0]), 1);
`ifdef SOCKET_RR_OVF_EN
        chk("t3_ovf_set", int'(o_ovf), 1);
        tick();
        tick();
        chk("t3_ovf_sticky", int'(o_ovf), 1);
        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("t3_ovf_clr", int'(o_ovf), 0);
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 8'(8'h30 + i)});
        i_full = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t3_full_drained", int'(o_full), 0);

        // Backpressure hold and resume after last grant
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_data  = {8'(8'h50 + i), 8'(8'h40 + i)};
            i_wr_en = 2'b11;
            tick();
        end
        i_wr_en = '0;
        exp_q.push_back({1'b0, 8'h40});
        i_full = 1'b0;
        tick();
        i_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_dv", int'(o_dv), 0);
            chk("t4_hold_level", int'(o_level), (2 << LVL_W) | 1);
        end
        exp_q.push_back({1'b1, 8'h50});
        exp_q.push_back({1'b0, 8'h41});
        exp_q.push_back({1'b1, 8'h51});
        i_full = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Steady write+pop at level 2, then one extra write
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_data  = {8'(8'h60 + i), 8'h00};
            i_wr_en = 2'b10;
            tick();
        end
        chk("t5_level_init", lvl(1), 2);
        chk("t5_afull_init", int'(o_afull[1]), 0);
        i_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b1, 8'(8'h60 + i)});
            i_data  = {8'(8'h62 + i), 8'h00};
            tick();
            chk("t5_level_steady", lvl(1), 2);
            chk("t5_afull_steady", int'(o_afull[1]), 0);
        end
        i_full = 1'b1;
        i_data = {8'h66, 8'h00};
        tick();
        i_wr_en = '0;
        chk("t5_level_extra", lvl(1), 3);
        chk("t5_afull_extra", int'(o_afull[1]), 1);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'(8'h64 + i)});
        i_full = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset while a word is on the output
        do_reset();
        i_full  = 1'b1;
        i_data  = {8'h80, 8'h70};
        i_wr_en = 2'b11;
        tick();
        i_data  = {8'h00, 8'h71};
        i_wr_en = 2'b01;
        tick();
        i_wr_en = '0;
        i_full  = 1'b0;
        tick();
        chk("t6_dv_before", int'(o_dv), 1);
        chk("t6_data_before", int'(o_data), 'h70);
        rst = 1'b1;
        #1;
        chk("t6_dv_rst", int'(o_dv), 0);
        chk("t6_level_rst", int'(o_level), 0);
        chk("t6_full_rst", int'(o_full), 0);
        tick();
        rst     = 1'b0;
        i_data  = {8'h90, 8'h00};
        i_wr_en = 2'b10;
        exp_q.push_back({1'b1, 8'h90});
        tick();
        i_wr_en = '0;
        for (int i = 0; i < 4; i++) tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
